// File: rtl/store_buffer.sv
// Store buffer: queues aligned stores (base + signed offset) and drains
// them to the data cache in acceptance order through a two-state drain FSM.
// Build option: define STORE_BUFFER_FWD_EN for load-to-store forwarding.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   st_valid/st_ready     store handshake (accepted when both high)
//   st_base, st_offset    address operands (offset is sign-extended)
//   st_data               store data
//   mem_req/mem_ack       cache write handshake (ack dequeues the head)
//   mem_addr, mem_wdata   head entry, stable while mem_req is high
//   misalign              one-cycle pulse when a store is dropped
//   count                 occupied entries
//   ld_addr/ld_hit/ld_data  forwarding lookup (zero when disabled)
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   input  logic [31:0]              st_base,
   input  logic [15:0]              st_offset,
   input  logic [31:0]              st_data,
   output logic                     st_ready,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_ack,
   output logic                     misalign,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [31:0]              ld_addr,
   output logic                     ld_hit,
   output logic [31:0]              ld_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic {IDLE, REQ} state_t;

   state_t          state, state_nxt;
   logic [31:0]     addr_q [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count_q;
   logic [31:0]     eff_addr;
   logic            accept, enq, deq;

   // Carry out of bit 31 is dropped by the 32-bit result.
   assign eff_addr = st_base + {{16{st_offset[15]}}, st_offset};

   assign st_ready = (count_q < FULL);
   assign accept   = st_valid && st_ready;
   assign enq      = accept && (eff_addr[1:0] == 2'b00);
   assign deq      = mem_req && mem_ack;
   assign count    = count_q;

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail] <= eff_addr;
         data_q[tail] <= st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count_q  <= '0;
         misalign <= 1'b0;
      end else begin
         misalign <= accept && (eff_addr[1:0] != 2'b00);
         if (enq)
            tail <= tail + PW'(1);
         if (deq)
            head <= head + PW'(1);
         case ({enq, deq})
            2'b10:   count_q <= count_q + ONE;
            2'b01:   count_q <= count_q - ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Drain FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Drain FSM: next state. Entering REQ on the enqueue edge itself
   // gives a one-cycle enqueue-to-request latency from empty.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (count_q != '0 || enq)
                  state_nxt = REQ;
         REQ:  if (deq && count_q == ONE && !enq)
                  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Drain FSM: outputs. Address/data are forced to zero outside REQ.
   always_comb begin
      mem_req   = (state == REQ);
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == REQ) begin
         mem_addr  = addr_q[head];
         mem_wdata = data_q[head];
      end
   end

`ifdef STORE_BUFFER_FWD_EN
   // Scan oldest to youngest so the youngest match wins.
   logic [PW-1:0] fwd_idx;
   always_comb begin
      ld_hit  = 1'b0;
      ld_data = '0;
      fwd_idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head + PW'(k);
         if (CW'(k) < count_q && addr_q[fwd_idx] == ld_addr) begin
            ld_hit  = 1'b1;
            ld_data = data_q[fwd_idx];
         end
      end
   end
`else
   logic unused_ld;
   assign unused_ld = ^ld_addr;
   assign ld_hit    = 1'b0;
   assign ld_data   = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer with a queue-based reference model.
// Directed scenarios followed by randomized traffic.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          st_valid = 1'b0;
   logic [31:0]   st_base = '0;
   logic [15:0]   st_offset = '0;
   logic [31:0]   st_data = '0;
   logic          st_ready;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack = 1'b0;
   logic          misalign;
   logic [CW-1:0] count;
   logic [31:0]   ld_addr = '0;
   logic          ld_hit;
   logic [31:0]   ld_data;

   int checks = 0;
   int passes = 0;

   logic [31:0] qa [$];
   logic [31:0] qd [$];
   bit          exp_mis = 0;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_base(st_base),
      .st_offset(st_offset), .st_data(st_data),
      .st_ready(st_ready), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .misalign(misalign),
      .count(count), .ld_addr(ld_addr),
      .ld_hit(ld_hit), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   // Advance one edge and apply the model's rules to the inputs
   // that were present at that edge.
   task automatic tick();
      logic signed [31:0] so;
      logic [31:0] ea;
      bit rdy, acc, dq;
      so  = $signed(st_offset);
      ea  = st_base + so;
      rdy = qa.size() < DEPTH;
      acc = st_valid && rdy;
      dq  = qa.size() > 0 && mem_ack;
      @(posedge clk);
      if (!rst_n) begin
         qa.delete();
         qd.delete();
         exp_mis = 0;
      end else begin
         if (dq) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
         end
         exp_mis = acc && (ea % 4 != 0);
         if (acc && ea % 4 == 0) begin
            qa.push_back(ea);
            qd.push_back(st_data);
         end
      end
      #1;
   endtask

   task automatic store(input logic [31:0] b, input logic [15:0] o,
                        input logic [31:0] d);
      st_valid = 1'b1;
      st_base = b;
      st_offset = o;
      st_data = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic drain();
      mem_ack = 1'b1;
      for (int i = 0; i < 40 && qa.size() > 0; i++)
         tick();
      mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (count !== '0 || mem_req !== 1'b0 || misalign !== 1'b0 ||
          st_ready !== 1'b1 || ld_hit !== 1'b0 || ld_data !== '0 ||
          mem_addr !== '0 || mem_wdata !== '0)
         $display("FAIL reset: cnt=%0d req=%b mis=%b rdy=%b hit=%b ld=%h a=%h d=%h required 0 0 0 1 0 0 0 0",
                  count, mem_req, misalign, st_ready, ld_hit, ld_data,
                  mem_addr, mem_wdata);
      else passes++;
   endtask

   task automatic test_basic();
      store(32'h100, 16'h0008, 32'hA5A5A5A5);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h108 ||
          mem_wdata !== 32'hA5A5A5A5)
         $display("FAIL basic_req: req=%b a=%h d=%h required 1 108 a5a5a5a5",
                  mem_req, mem_addr, mem_wdata);
      else passes++;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (count !== '0 || mem_req !== 1'b0)
         $display("FAIL basic_ack: cnt=%0d req=%b required 0 0",
                  count, mem_req);
      else passes++;
      // ack while idle is ignored
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (count !== '0 || mem_req !== 1'b0)
         $display("FAIL idle_ack: cnt=%0d req=%b required 0 0",
                  count, mem_req);
      else passes++;
   endtask

   task automatic test_addr_wrap();
      store(32'h00000010, 16'hFFFC, 32'h11);
      checks++;
      if (mem_addr !== 32'h0000000C)
         $display("FAIL neg_offset: addr=%h required 0000000c", mem_addr);
      else passes++;
      drain();
      store(32'hFFFFFFFC, 16'h0008, 32'h22);
      checks++;
      if (mem_addr !== 32'h00000004)
         $display("FAIL carry_wrap: addr=%h required 00000004", mem_addr);
      else passes++;
      drain();
   endtask

   task automatic test_full();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++)
         store(32'h500 + 32'(4 * i), 16'h0, 32'hD0 + 32'(i));
      st_valid = 1'b1;
      st_base = 32'h510;
      st_offset = 16'h0;
      st_data = 32'hD4;
      #1;
      checks++;
      if (st_ready !== 1'b0 || count !== CW'(4))
         $display("FAIL full: rdy=%b cnt=%0d required 0 4", st_ready, count);
      else passes++;
      tick();
      checks++;
      if (count !== CW'(4))
         $display("FAIL full_hold: cnt=%0d required 4", count);
      else passes++;
      // full buffer refuses even on the dequeue edge
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (count !== CW'(3) || st_ready !== 1'b1)
         $display("FAIL full_deq: cnt=%0d rdy=%b required 3 1",
                  count, st_ready);
      else passes++;
      tick();
      st_valid = 1'b0;
      checks++;
      if (count !== CW'(4))
         $display("FAIL fifth_acc: cnt=%0d required 4", count);
      else passes++;
      mem_ack = 1'b1;
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h500 + 32'(4 * i) ||
             mem_wdata !== 32'hD0 + 32'(i))
            $display("FAIL order%0d: req=%b a=%h d=%h required 1 %h %h",
                     i, mem_req, mem_addr, mem_wdata,
                     32'h500 + 32'(4 * i), 32'hD0 + 32'(i));
         else passes++;
         tick();
      end
      mem_ack = 1'b0;
      checks++;
      if (count !== '0 || mem_req !== 1'b0)
         $display("FAIL full_empty: cnt=%0d req=%b required 0 0",
                  count, mem_req);
      else passes++;
   endtask

   task automatic test_misalign();
      store(32'h100, 16'h0002, 32'h33);
      checks++;
      if (misalign !== 1'b1 || count !== '0 || mem_req !== 1'b0)
         $display("FAIL misalign: mis=%b cnt=%0d req=%b required 1 0 0",
                  misalign, count, mem_req);
      else passes++;
      tick();
      checks++;
      if (misalign !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL misalign_pulse: mis=%b req=%b required 0 0",
                  misalign, mem_req);
      else passes++;
   endtask

   task automatic test_forward();
      logic        eh;
      logic [31:0] ed;
      mem_ack = 1'b0;
      store(32'h200, 16'h0, 32'h1);
      store(32'h200, 16'h0, 32'h2);
      ld_addr = 32'h200;
      #1;
`ifdef STORE_BUFFER_FWD_EN
      eh = 1'b1;
      ed = 32'h2;
`else
      eh = 1'b0;
      ed = 32'h0;
`endif
      checks++;
      if (ld_hit !== eh || ld_data !== ed)
         $display("FAIL fwd_hit: hit=%b data=%h required %b %h",
                  ld_hit, ld_data, eh, ed);
      else passes++;
      ld_addr = 32'h204;
      #1;
      checks++;
      if (ld_hit !== 1'b0)
         $display("FAIL fwd_miss: hit=%b required 0", ld_hit);
      else passes++;
      drain();
   endtask

   task automatic test_reset_mid_drain();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++)
         store(32'h300 + 32'(4 * i), 16'h0, 32'hE0 + 32'(i));
      checks++;
      if (mem_req !== 1'b1 || count !== CW'(3))
         $display("FAIL pre_reset: req=%b cnt=%0d required 1 3",
                  mem_req, count);
      else passes++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (count !== '0 || mem_req !== 1'b0 || mem_addr !== '0)
         $display("FAIL mid_reset: cnt=%0d req=%b a=%h required 0 0 0",
                  count, mem_req, mem_addr);
      else passes++;
      store(32'h400, 16'h0, 32'h44);
      checks++;
      if (mem_addr !== 32'h400 || mem_wdata !== 32'h44 || count !== CW'(1))
         $display("FAIL post_reset: a=%h d=%h cnt=%0d required 400 44 1",
                  mem_addr, mem_wdata, count);
      else passes++;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || count !== '0)
         $display("FAIL post_reset_drain: req=%b cnt=%0d required 0 0",
                  mem_req, count);
      else passes++;
   endtask

   task automatic test_random();
      int          o;
      bit          eh;
      logic [31:0] ed;
      int          bad;
      for (int c = 0; c < 400; c++) begin
         st_valid = 1'($urandom_range(0, 1));
         st_base = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         o = ($urandom_range(0, 7) == 0) ? 1 : 4 * ($urandom_range(0, 4) - 2);
         st_offset = 16'(o);
         st_data = $urandom;
         mem_ack = ($urandom_range(0, 2) != 0);
         ld_addr = 32'h0FF8 + 32'(4 * $urandom_range(0, 11));
         #1;
         eh = 0;
         ed = '0;
`ifdef STORE_BUFFER_FWD_EN
         foreach (qa[i])
            if (qa[i] == ld_addr) begin
               eh = 1;
               ed = qd[i];
            end
`endif
         bad = 0;
         if (st_ready !== (qa.size() < DEPTH)) bad |= 1;
         if (count !== CW'(qa.size())) bad |= 2;
         if (mem_req !== (qa.size() > 0)) bad |= 4;
         if (qa.size() > 0 && (mem_addr !== qa[0] || mem_wdata !== qd[0]))
            bad |= 8;
         if (misalign !== exp_mis) bad |= 16;
         if (ld_hit !== eh || ld_data !== ed) bad |= 32;
         checks++;
         if (bad != 0)
            $display("FAIL random c%0d code=%0d: rdy=%b cnt=%0d req=%b a=%h mis=%b hit=%b ld=%h required cnt=%0d mis=%b hit=%b ld=%h",
                     c, bad, st_ready, count, mem_req, mem_addr, misalign,
                     ld_hit, ld_data, qa.size(), exp_mis, eh, ed);
         else passes++;
         tick();
      end
      st_valid = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_addr_wrap();
      test_full();
      test_misalign();
      test_forward();
      test_reset_mid_drain();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
